tuner_cfg_arbiter: RTL and testbench

// Round-robin scheduler that shares one configuration engine (e.g. the tuner I2C/SPI

---
 rtl/tuner_cfg_arbiter_if.sv | 12 +
 rtl/tuner_cfg_arbiter.sv | 94 +++++++++
 tb/tb_tuner_cfg_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tuner_cfg_arbiter_if.sv
// tuner_cfg_arbiter_if: request/grant bus between tuner channels, the arbiter and the shared config engine
interface tuner_cfg_arbiter_if #(parameter int N_CH = 4);
    logic [N_CH-1:0] REQ_LEVEL;
    logic            DONE;
    logic [N_CH-1:0] GRANT;
    logic            START;
    logic            BUSY;
    logic            TIMEOUT_ERR;
    logic [N_CH-1:0] PENDING;
    modport slave (input REQ_LEVEL, DONE, output GRANT, START, BUSY, TIMEOUT_ERR, PENDING);
    modport master (output REQ_LEVEL, DONE, input GRANT, START, BUSY, TIMEOUT_ERR, PENDING);
endinterface

// File: rtl/tuner_cfg_arbiter.sv
// tuner_cfg_arbiter: round-robin START/DONE scheduler sharing one config engine among N_CH channels, with watchdog
module tuner_cfg_arbiter #(
    parameter int N_CH    = 4,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic CLOCK,
    input  logic RESET,
    tuner_cfg_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_CH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t          state_q, state_d;
    logic [N_CH-1:0] prev_q, pend_q, pend_d, grant_q, grant_d, edge_v, win_oh;
    logic            start_q, start_d, terr_q, terr_d, found;
    logic [PW-1:0]   rr_q, rr_d, win, idx;
    logic [TO_W-1:0] wd_q, wd_d;
    // first pending channel at or after rr_q, wrapping
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PW'((int'(rr_q) + k) % N_CH);
            if (!found && pend_q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    assign win_oh = N_CH'(1) << win;
    assign edge_v = bus.REQ_LEVEL & ~prev_q;
    // edges are OR-ed in after the grant clear so a same-cycle re-request survives
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        start_d = 1'b0;
        terr_d  = 1'b0;
        rr_d    = rr_q;
        wd_d    = wd_q;
        pend_d  = pend_q | edge_v;
        case (state_q)
            IDLE: if (found) begin
                state_d = ISSUE;
                grant_d = win_oh;
                start_d = 1'b1;
                pend_d  = (pend_q & ~win_oh) | edge_v;
                rr_d    = (win == PW'(N_CH - 1)) ? '0 : win + 1'b1;
            end
            ISSUE: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (bus.DONE) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= IDLE;
            prev_q  <= '1;
            pend_q  <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            rr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.REQ_LEVEL;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            start_q <= start_d;
            terr_q  <= terr_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end
    assign bus.GRANT       = grant_q;
    assign bus.START       = start_q;
    assign bus.BUSY        = state_q != IDLE;
    assign bus.TIMEOUT_ERR = terr_q;
    assign bus.PENDING     = pend_q;
endmodule

// File: tb/tb_tuner_cfg_arbiter.sv
// tb_tuner_cfg_arbiter: directed scenarios plus random traffic against a job-level reference model
module tb_tuner_cfg_arbiter;
    localparam int N = 4;
    localparam int TO = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int nterr = 0;
    logic [3:0] glog[$];
    bit [3:0] m_prev, m_pend;
    int m_owner, m_age, m_rr;
    bit m_start, m_terr;
    tuner_cfg_arbiter_if #(.N_CH(N)) bus ();
    tuner_cfg_arbiter #(.N_CH(N), .TO_W(16), .TIMEOUT(TO)) dut (.CLOCK(clk), .RESET(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    // one job owner at a time: -1 idle, m_start marks its START cycle, m_age counts waiting cycles
    task automatic model_step(input bit [3:0] req, input bit done, input bit r);
        bit [3:0] e;
        if (r) begin
            m_prev = '1; m_pend = '0; m_owner = -1; m_age = 0; m_rr = 0; m_start = 0; m_terr = 0;
            return;
        end
        e = req & ~m_prev;
        m_terr = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && m_pend[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
            if (m_owner >= 0) begin
                m_start = 1;
                m_pend[m_owner] = 0;
                m_rr = (m_owner + 1) % N;
            end
        end else if (m_start) begin
            m_start = 0;
            m_age = 0;
        end else if (done) begin
            m_owner = -1;
        end else if (m_age == TO - 1) begin
            m_terr = 1;
            m_owner = -1;
        end else m_age++;
        m_pend |= e;
        m_prev = req;
    endtask
    task automatic cycle(input logic [3:0] req, input logic done, input logic r);
        @(negedge clk);
        bus.REQ_LEVEL = req;
        bus.DONE = done;
        rst = r;
        @(posedge clk);
        #1;
        model_step(req, done, r);
        chk("grant", bus.GRANT, (m_owner < 0) ? 4'b0 : 4'(1 << m_owner));
        chk("start", bus.START, m_start);
        chk("busy", bus.BUSY, m_owner >= 0);
        chk("terr", bus.TIMEOUT_ERR, m_terr);
        chk("pending", bus.PENDING, m_pend);
        if (bus.START) glog.push_back(bus.GRANT);
        if (bus.TIMEOUT_ERR) nterr++;
    endtask
    function automatic logic [15:0] gseq();
        logic [15:0] s = '0;
        foreach (glog[i]) s = {s[11:0], glog[i]};
        return s;
    endfunction
    task automatic restart();
        cycle(4'b0, 1'b0, 1'b1);
        cycle(4'b0, 1'b0, 1'b0);
        glog.delete();
        nterr = 0;
    endtask
    initial begin
        logic [3:0] req;
        int n;
        bus.REQ_LEVEL = 4'b0001;
        bus.DONE = 1'b0;
        cycle(4'b0001, 0, 1);
        cycle(4'b0001, 0, 1);
        chk("rst_grant", bus.GRANT, 4'b0);
        chk("rst_pend", bus.PENDING, 4'b0);
        repeat (3) cycle(4'b0001, 0, 0);
        chk("s1_no_start", glog.size(), 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0001, 0, 0);
        cycle(4'b0001, 0, 0);
        chk("s1_start", {bus.START, bus.GRANT}, 5'b10001);
        cycle(4'b0001, 0, 0);
        cycle(4'b0001, 1, 0);
        restart();
        cycle(4'b0110, 0, 0);
        cycle(4'b0110, 0, 0);
        cycle(4'b0110, 0, 0);
        cycle(4'b0110, 1, 0);
        cycle(4'b0110, 0, 0);
        chk("s2_regrant", {bus.START, bus.GRANT}, 5'b10100);
        chk("s2_order", gseq(), 16'h0024);
        restart();
        cycle(4'b1111, 0, 0);
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!bus.START && n < 12) begin
                cycle(4'b1111, 0, 0);
                n++;
            end
            chk("s3_start_seen", n < 12, 1'b1);
            repeat (4) cycle(4'b1111, 0, 0);
            cycle(4'b1111, 1, 0);
        end
        chk("s3_order", gseq(), 16'h1248);
        chk("s3_pend_empty", bus.PENDING, 4'b0);
        restart();
        cycle(4'b0001, 0, 0);
        cycle(4'b0011, 0, 0);
        repeat (30) cycle(4'b0011, 0, 0);
        chk("s4_terr_count", nterr, 1);
        chk("s4_order", gseq(), 16'h0012);
        restart();
        cycle(4'b1000, 0, 0);
        repeat (4) cycle(4'b1000, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b1000, 0, 0);
        chk("s5_pend3", bus.PENDING[3], 1'b1);
        cycle(4'b1000, 1, 0);
        cycle(4'b1000, 0, 0);
        cycle(4'b1000, 0, 0);
        chk("s5_order", gseq(), 16'h0088);
        restart();
        cycle(4'b1011, 0, 0);
        cycle(4'b1011, 0, 0);
        repeat (2) cycle(4'b1011, 0, 0);
        chk("s6_pend_before", bus.PENDING, 4'b1010);
        cycle(4'b1011, 0, 1);
        chk("s6_cleared", {bus.GRANT, bus.BUSY, bus.PENDING}, 9'b0);
        glog.delete();
        repeat (10) cycle(4'b1011, 0, 0);
        chk("s6_no_start", glog.size(), 0);
        restart();
        req = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            req ^= 4'($urandom & $urandom);
            cycle(req, (i % 600 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0),
                  $urandom_range(0, 399) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
